// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, ALU select codes and the one-hot T-state encoding.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_ALU = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0, ALU_SUB   = 4'h1, ALU_AND   = 4'h2, ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4, ALU_NOTA  = 4'h5, ALU_INCA  = 4'h6, ALU_DECA  = 4'h7,
    ALU_SHL   = 4'h8, ALU_SHR   = 4'h9, ALU_ROL   = 4'hA, ALU_ROR   = 4'hB,
    ALU_PASSB = 4'hC, ALU_NEGA  = 4'hD, ALU_SWAPN = 4'hE, ALU_REVA  = 4'hF
  } alu_sel_e;

  // Bits 5:0 double as the externally visible one-hot t_state.
  typedef enum logic [6:0] {
    T1   = 7'b0000001,
    T2   = 7'b0000010,
    T3   = 7'b0000100,
    T4   = 7'b0001000,
    T5   = 7'b0010000,
    T6   = 7'b0100000,
    HALT = 7'b1000000
  } tstate_e;

endpackage

// File: rtl/sap_tstate_counter.sv
// One-hot ring counter T1..T6 with early return to T1 and a terminal HALT state.
module sap_tstate_counter
  import sap_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  input  logic    early_ret,
  input  logic    halt_req,
  output tstate_e state
);

  tstate_e state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= T1;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (adv) begin
      unique case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = halt_req ? HALT : (early_ret ? T1 : T5);
        T5:      state_next = early_ret ? T1 : T6;
        T6:      state_next = T1;
        HALT:    state_next = HALT;
        default: state_next = T1;
      endcase
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state counter plus per-state control-word decode from the IR.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ARG_W     = 4,
  parameter int FAST_EXEC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic [OPC_W+ARG_W-1:0] ir,
  output logic                   ep,
  output logic                   cp,
  output logic                   lm,
  output logic                   ce,
  output logic                   li,
  output logic                   ei,
  output logic                   la,
  output logic                   lb,
  output logic                   eu,
  output logic [ARG_W-1:0]       alu_sel,
  output logic                   ea,
  output logic                   lo,
  output logic                   halted,
  output logic [5:0]             t_state
);

  tstate_e          state;
  logic [OPC_W-1:0] opcode;
  logic [ARG_W-1:0] arg;
  logic             adv;
  logic             act;
  logic             is_ld;
  logic             early_ret;
  logic             halt_req;

  assign opcode  = ir[OPC_W+ARG_W-1 -: OPC_W];
  assign arg     = ir[ARG_W-1:0];
  assign halted  = (state == HALT);
  assign t_state = state[5:0];
  assign adv     = (run | step) & ~halted;
  // Controls are also masked by rst so nothing fires while reset holds the counter at T1.
  assign act     = adv & ~rst;
  assign is_ld   = (opcode == OPC_W'(OP_LDA)) || (opcode == OPC_W'(OP_LDB));

  always_comb begin
    halt_req  = (state == T4) && (opcode == OPC_W'(OP_HLT));
    early_ret = (FAST_EXEC != 0) &&
                (((state == T4) && !is_ld) || ((state == T5) && is_ld));
  end

  sap_tstate_counter u_tstate (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .early_ret (early_ret),
    .halt_req  (halt_req),
    .state     (state)
  );

  always_comb begin
    ep = 1'b0; cp = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; lb = 1'b0; eu = 1'b0; ea = 1'b0; lo = 1'b0;
    alu_sel = '0;
    if (act) begin
      unique case (state)
        T1: begin ep = 1'b1; lm = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ce = 1'b1; li = 1'b1; end
        T4: begin
          if (is_ld) begin
            ei = 1'b1; lm = 1'b1;
          end else if (opcode == OPC_W'(OP_ALU)) begin
            eu = 1'b1; la = 1'b1; alu_sel = arg;
          end else if (opcode == OPC_W'(OP_OUT)) begin
            ea = 1'b1; lo = 1'b1;
          end
        end
        T5: begin
          if (opcode == OPC_W'(OP_LDA)) begin
            ce = 1'b1; la = 1'b1;
          end else if (opcode == OPC_W'(OP_LDB)) begin
            ce = 1'b1; lb = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: normal and FAST_EXEC instances against a step-count model.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] ir = 8'h00;

  logic ep_s, cp_s, lm_s, ce_s, li_s, ei_s, la_s, lb_s, eu_s, ea_s, lo_s, halted_s;
  logic ep_f, cp_f, lm_f, ce_f, li_f, ei_f, la_f, lb_f, eu_f, ea_f, lo_f, halted_f;
  logic [3:0] alu_sel_s, alu_sel_f;
  logic [5:0] ts_s, ts_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sap_control_sequencer #(.OPC_W(4), .ARG_W(4), .FAST_EXEC(0)) u_slow (
    .clk(clk), .rst(rst), .run(run), .step(step), .ir(ir),
    .ep(ep_s), .cp(cp_s), .lm(lm_s), .ce(ce_s), .li(li_s), .ei(ei_s),
    .la(la_s), .lb(lb_s), .eu(eu_s), .alu_sel(alu_sel_s), .ea(ea_s), .lo(lo_s),
    .halted(halted_s), .t_state(ts_s)
  );

  sap_control_sequencer #(.OPC_W(4), .ARG_W(4), .FAST_EXEC(1)) u_fast (
    .clk(clk), .rst(rst), .run(run), .step(step), .ir(ir),
    .ep(ep_f), .cp(cp_f), .lm(lm_f), .ce(ce_f), .li(li_f), .ei(ei_f),
    .la(la_f), .lb(lb_f), .eu(eu_f), .alu_sel(alu_sel_f), .ea(ea_f), .lo(lo_f),
    .halted(halted_f), .t_state(ts_f)
  );

  // Control word order: {ep,cp,lm,ce,li,ei,la,lb,eu,ea,lo}
  logic [10:0] ctl_s, ctl_f;
  assign ctl_s = {ep_s, cp_s, lm_s, ce_s, li_s, ei_s, la_s, lb_s, eu_s, ea_s, lo_s};
  assign ctl_f = {ep_f, cp_f, lm_f, ce_f, li_f, ei_f, la_f, lb_f, eu_f, ea_f, lo_f};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within instruction as a step number 1..6 plus a halted flag.
  int k_s = 1, k_f = 1;
  bit h_s = 1'b0, h_f = 1'b0;

  function automatic int last_step(input logic [3:0] op, input bit fast);
    if (!fast) return 6;
    if (op == 4'h0 || op == 4'h1) return 5;
    return 4;
  endfunction

  function automatic int next_k(input int k, input logic [3:0] op, input bit fast);
    return (k >= last_step(op, fast)) ? 1 : k + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k_s <= 1; k_f <= 1; h_s <= 1'b0; h_f <= 1'b0;
    end else begin
      if ((run || step) && !h_s) begin
        if (k_s == 4 && ir[7:4] == 4'hF) h_s <= 1'b1;
        else k_s <= next_k(k_s, ir[7:4], 1'b0);
      end
      if ((run || step) && !h_f) begin
        if (k_f == 4 && ir[7:4] == 4'hF) h_f <= 1'b1;
        else k_f <= next_k(k_f, ir[7:4], 1'b1);
      end
    end
  end

  // Expected {control word, alu_sel} for a given step.
  function automatic logic [14:0] exp_out(input int k, input bit h, input logic [7:0] instr,
                                          input logic r, input logic go);
    logic [3:0] op;
    op = instr[7:4];
    if (r || h || !go) return '0;
    case (k)
      1: return {11'h500, 4'h0};
      2: return {11'h200, 4'h0};
      3: return {11'h0C0, 4'h0};
      4: begin
        if (op == 4'h0 || op == 4'h1) return {11'h120, 4'h0};
        if (op == 4'h2)               return {11'h014, instr[3:0]};
        if (op == 4'hE)               return {11'h003, 4'h0};
        return '0;
      end
      5: begin
        if (op == 4'h0) return {11'h090, 4'h0};
        if (op == 4'h1) return {11'h088, 4'h0};
        return '0;
      end
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("ctl_slow",     {ctl_s, alu_sel_s}, exp_out(k_s, h_s, ir, rst, run | step));
    chk("halted_slow",  halted_s, h_s);
    chk("tstate_slow",  ts_s, h_s ? 0 : (1 << (k_s - 1)));
    chk("ctl_fast",     {ctl_f, alu_sel_f}, exp_out(k_f, h_f, ir, rst, run | step));
    chk("halted_fast",  halted_f, h_f);
    chk("tstate_fast",  ts_f, h_f ? 0 : (1 << (k_f - 1)));
  end

  task automatic do_reset(input logic [7:0] instr, input logic r);
    @(posedge clk); #1 rst = 1'b1; ir = instr; run = r; step = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    logic [10:0] lda_seq [6];
    lda_seq = '{11'h500, 11'h200, 11'h0C0, 11'h120, 11'h090, 11'h000};

    // Reset with run high: controls silent, T1 shown.
    do_reset(8'h05, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctl", ctl_s, 0);
    chk("rst_tstate", ts_s, 6'b000001);
    @(posedge clk); #1 rst = 1'b0;

    // LDA 5 free-running on the normal instance.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lda_seq", ctl_s, lda_seq[c]);
    end
    @(negedge clk);
    chk("lda_wrap", ts_s, 6'b000001);

    // ALU op A on the fast instance returns to T1 right after T4.
    do_reset(8'h2A, 1'b1);
    repeat (4) @(negedge clk);
    chk("alu_eu", eu_f, 1);
    chk("alu_la", la_f, 1);
    chk("alu_sel", alu_sel_f, 4'hA);
    @(negedge clk);
    chk("alu_fast_wrap", ts_f, 6'b000001);
    repeat (8) @(negedge clk);

    // HLT parks both instances until reset.
    do_reset(8'hF0, 1'b1);
    repeat (5) @(negedge clk);
    chk("hlt_halted", halted_s, 1);
    chk("hlt_tstate", ts_s, 0);
    step = 1'b1;
    repeat (20) @(negedge clk);
    chk("hlt_still", {halted_s, ts_s, ctl_s}, {1'b1, 6'b0, 11'h0});
    do_reset(8'h05, 1'b1);
    @(negedge clk);
    chk("hlt_exit_halted", halted_s, 0);
    chk("hlt_exit_tstate", ts_s, 6'b000001);

    // Single-step with three isolated pulses.
    do_reset(8'h05, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step = (c % 2 == 1);
      @(posedge clk); #1;
    end
    step = 1'b0;
    @(negedge clk);
    chk("step_tstate", ts_s, 6'b001000);
    chk("step_idle_ctl", ctl_s, 0);

    // Async reset in T5 of LDA kills la at once.
    do_reset(8'h05, 1'b1);
    repeat (4) @(posedge clk);
    #1 chk("t5_la_before", la_s, 1);
    #2 rst = 1'b1;
    #1 chk("t5_la_after", la_s, 0);
    chk("t5_tstate_after", ts_s, 6'b000001);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_restart", ctl_s, 11'h500);

    // Undefined opcode behaves as NOP, then fetch continues.
    do_reset(8'h73, 1'b1);
    repeat (4) @(negedge clk);
    chk("nop_t4", ctl_s, 0);
    repeat (3) @(negedge clk);
    chk("nop_next_fetch", ctl_s, 11'h500);
    repeat (6) @(negedge clk);

    // run and step together advance only once per cycle.
    do_reset(8'h05, 1'b1);
    step = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_step_tstate", ts_s, 6'b000100);
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
